mac_acc_datapath: RTL
=====================

# mac_acc_datapath

Arithmetic datapath downstream of the MAC controller FSM and streamer. It consumes the `ctrl_engine_t` word from the FSM and the `a`/`b`/`c` operand streams from the streamer, and produces the `d` result stream and the `flags_engine_t` word. It runs either element-wise (`d = (a*b>>>shift)+c`) or as a length-`len` dot product (`d = Σ(a*b>>>shift)+c`). It holds a two-stage valid/ready pipeline: a product register and an output register.

## Interface
- `DW`, default 32: operand/result width. Fixed at 32 for this release.
- `clk_i` input, 1 bit: single clock.
- `rst_i` input, 1 bit: reset. Synchronous, active-high.
- `a_valid_i`/`a_ready_o`/`a_data_i[DW-1:0]`: operand A stream, signed.
- `b_valid_i`/`b_ready_o`/`b_data_i[DW-1:0]`: operand B stream, signed.
- `c_valid_i`/`c_ready_o`/`c_data_i[DW-1:0]`: addend C stream, signed.
- `d_valid_o`/`d_ready_i`/`d_data_o[DW-1:0]`: result D stream.
- `ctrl_i` input, `ctrl_engine_t`: fields `clear`, `enable`, `simple_mul`, `start`, `shift[4:0]`, `len[10:0]`.
- `flags_o` output, `flags_engine_t`: fields `cnt[10:0]`, `acc_done`.

## Operation
- **Product stage (P).**
  - Fires when `a_valid_i & b_valid_i & enable & (P empty | P advancing)`.
  - `a_ready_o = b_valid_i & p_accept`; `b_ready_o = a_valid_i & p_accept`. This is join semantics: no one-sided consumption.
  - Computes the full 64-bit signed product, then `>>> shift` (arithmetic), then keeps the low 32 bits as `prod`.
- **Output register (O).** Accepts when empty or when `d_ready_i` is high.
- **`last` term.** `last` = `simple_mul | (cnt+1 == len_eff)`. `len_eff` = `len`, or 1 when `len == 0`.
- **P advance condition.**
  - P holds valid and `enable` is high, and
  - either `!last`, or `last & c_valid_i & O accepts`.
- **`c_ready_o`** = P advance `& last`.
- **Simple mode (`simple_mul=1`).** Each P advance loads O with `prod + c`.
  - `cnt` stays 0.
  - `acc_done` pulses for every result.
- **Accumulate mode.**
  - Non-last advance: `acc += prod`, `cnt += 1`.
  - Last advance: O loads `acc + prod + c`; `acc` and `cnt` return to 0; `acc_done` pulses one cycle.
- **Arithmetic.** All adds are 32-bit two's complement and wrap silently.
- **`start`.** Pulse sets `acc=0`, `cnt=0`. A same-cycle P advance is applied after the reset, i.e. it counts as element 1.
- **`enable=0`.**
  - No P fire or advance.
  - `a_ready_o`, `b_ready_o`, `c_ready_o` are low.
  - A pending O keeps presenting `d_valid_o` and may drain.
- **`clear`.** Synchronous, identical to reset for all state. Priority order: `rst_i`/`clear` > `start` > data.
- **`ctrl_i.len` and `shift`.**
  - Sampled each cycle.
  - Must be held stable by the FSM between `start` and the final `acc_done`.
  - Changing them mid-vector gives defined but unspecified results, and is not tested.

## Timing
- **Reset values.** All of the following are 0: `d_valid_o`, `d_data_o`, `flags_o.cnt`, `flags_o.acc_done`, `acc`, P valid.
  - `a_ready_o`/`b_ready_o`/`c_ready_o` are combinational and are 0 while `enable=0`.
- **Latency, simple mode.** a/b handshake in cycle t → P valid t+1 → `d_valid_o` t+2, with no backpressure.
- **Latency, accumulate mode.** `d_valid_o` is asserted the cycle after the last element's P advance.
- **Throughput.** One element per cycle.
- **`d_valid_o`.** Once high, `d_valid_o` and `d_data_o` hold stable until `d_ready_i`.
- **`flags_o`.** Registered. `acc_done` is high in the same cycle `d_valid_o` first rises for that result.
- **`cnt`.** Reflects elements accumulated so far. `len=1024` requires `cnt` to reach 1023 without overflow (11 bits).
- **Simultaneous events.**
  - O draining (`d_ready_i`) and loading in the same cycle is legal.
  - P receiving a new product while advancing is legal.
  - `clear` during a stall discards everything, including an un-acked O.

## Structure
- **Shared package (`mac_package`).** Uses the existing `ctrl_engine_t`, `flags_engine_t` and `MAC_CNT_LEN`. Add `MAC_DATA_WIDTH = 32` and `MAC_PROD_WIDTH = 64`.
- **Sub-module `mac_prod_stage`.** Signed multiply, shift, truncate, and the P valid/ready register. Keeps multiplier retiming isolated.
- **Top level.** Contains the accumulator, counter, C join, O register and flags.

## Test plan
1. **Simple mode, basic result.** Stimulus: `simple_mul=1`, `shift=0`, a=3, b=-4, c=10. Required: `d=0xFFFFFFFE` at t+2; `acc_done` pulses; `cnt=0`.
2. **Accumulate mode, full vector.** Stimulus: `len=4`, `shift=1`, a={2,4,6,8}, b=1, c=5. Required:
   - `cnt` steps 1,2,3 then 0.
   - Single `d=15` with one `acc_done` pulse.
   - `c_ready_o` high only on element 4.
3. **Backpressure.** Stimulus: simple mode, 3 back-to-back elements, `d_ready_i=0` for 5 cycles. Required:
   - First result held stable.
   - `a_ready_o` drops once P is full.
   - All 3 results emerge in order after release; none lost or duplicated.
4. **`clear` mid-vector.** Stimulus: `clear` after 2 of 4 elements. Required:
   - `cnt=0`, `d_valid_o=0` next cycle.
   - A following vector {1,1,1,1}×1, c=0 yields d=4.
5. **`start` and `len=0`.** Stimulus: `start` coincident with the first P advance, `len=0`, a=7, b=7, c=0. Required: d=49 per element; `acc_done` on each.
6. **Extreme product.** Stimulus: a=b=0x80000000, `shift=31`, c=0, simple mode. Required: d=0x80000000.

Source files
------------

// File: rtl/mac_package.sv
// ---------------------------------------------------------------------------
// mac_package
// Shared types and constants for the MAC engine: the control word driven by
// the controller FSM, the flags word returned by the datapath, widths, and
// the product scaling helper used by the product stage.
// ---------------------------------------------------------------------------
package mac_package;

    localparam int MAC_CNT_LEN    = 11;
    localparam int MAC_DATA_WIDTH = 32;
    localparam int MAC_PROD_WIDTH = 64;

    // Control word from the controller FSM
    typedef struct packed {
        logic                   clear;
        logic                   enable;
        logic                   simple_mul;
        logic                   start;
        logic [4:0]             shift;
        logic [MAC_CNT_LEN-1:0] len;
    } ctrl_engine_t;

    // Status word back to the controller FSM
    typedef struct packed {
        logic [MAC_CNT_LEN-1:0] cnt;
        logic                   acc_done;
    } flags_engine_t;

    // Full-width signed product, arithmetic right shift, keep the low word.
    // Operands are sign-extended to the product width so the multiply is an
    // exact signed product before scaling.
    function automatic logic [MAC_DATA_WIDTH-1:0] mac_scale_product(
        input logic [MAC_DATA_WIDTH-1:0] a,
        input logic [MAC_DATA_WIDTH-1:0] b,
        input logic [4:0]                shift
    );
        logic signed [MAC_PROD_WIDTH-1:0] a_ext;
        logic signed [MAC_PROD_WIDTH-1:0] b_ext;
        logic signed [MAC_PROD_WIDTH-1:0] full;
        a_ext = {{(MAC_PROD_WIDTH-MAC_DATA_WIDTH){a[MAC_DATA_WIDTH-1]}}, a};
        b_ext = {{(MAC_PROD_WIDTH-MAC_DATA_WIDTH){b[MAC_DATA_WIDTH-1]}}, b};
        full  = a_ext * b_ext;
        return MAC_DATA_WIDTH'(full >>> shift);
    endfunction

endpackage

// File: rtl/mac_prod_stage.sv
// ---------------------------------------------------------------------------
// mac_prod_stage
// Product stage (P) of the MAC datapath. Joins the A and B operand streams,
// forms the scaled signed product and holds it in a single valid/ready
// register until the downstream logic advances it.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             synchronous clear, same effect as reset
//   enable_i            gates all operand consumption
//   shift_i             arithmetic right shift applied to the 64-bit product
//   a_* / b_*           operand streams (valid/ready/data), signed
//   p_valid_o/p_data_o  product register contents
//   p_advance_i         downstream consumes the product this cycle
// ---------------------------------------------------------------------------
module mac_prod_stage
    import mac_package::*;
#(
    parameter int DW = MAC_DATA_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic [4:0]    shift_i,
    input  logic          a_valid_i,
    output logic          a_ready_o,
    input  logic [DW-1:0] a_data_i,
    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic [DW-1:0] b_data_i,
    output logic          p_valid_o,
    output logic [DW-1:0] p_data_o,
    input  logic          p_advance_i
);

    logic          p_valid_r;
    logic [DW-1:0] p_data_r;
    logic          p_accept_s;
    logic          p_fire_s;
    logic [DW-1:0] prod_s;

    // P can take a new product when empty or when its content leaves this cycle
    assign p_accept_s = enable_i & (~p_valid_r | p_advance_i);
    assign p_fire_s   = a_valid_i & b_valid_i & p_accept_s;

    // Join: each side is only offered ready when the other side is valid,
    // so neither operand can be consumed alone
    assign a_ready_o  = b_valid_i & p_accept_s;
    assign b_ready_o  = a_valid_i & p_accept_s;

    assign prod_s     = mac_scale_product(a_data_i, b_data_i, shift_i);

    // Product register: load on fire, empty on an advance without refill
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            p_valid_r <= 1'b0;
            p_data_r  <= {DW{1'b0}};
        end else if (p_fire_s) begin
            p_valid_r <= 1'b1;
            p_data_r  <= prod_s;
        end else if (p_advance_i) begin
            p_valid_r <= 1'b0;
        end
    end

    assign p_valid_o = p_valid_r;
    assign p_data_o  = p_data_r;

endmodule

// File: rtl/mac_acc_datapath.sv
// ---------------------------------------------------------------------------
// mac_acc_datapath
// Arithmetic datapath of the MAC engine. Element-wise mode produces
// d = (a*b >>> shift) + c per element; accumulate mode produces one
// d = sum(a*b >>> shift) + c per vector of len elements (len 0 means 1).
// Two-stage pipeline: product register (mac_prod_stage) and output register.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   a_*, b_*              operand streams (valid/ready/data), signed
//   c_*                   addend stream, consumed once per result
//   d_*                   result stream
//   ctrl_i                control word (clear/enable/simple_mul/start/shift/len)
//   flags_o               registered element count and result-done pulse
// ---------------------------------------------------------------------------
module mac_acc_datapath
    import mac_package::*;
#(
    parameter int DW = MAC_DATA_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          a_valid_i,
    output logic          a_ready_o,
    input  logic [DW-1:0] a_data_i,
    input  logic          b_valid_i,
    output logic          b_ready_o,
    input  logic [DW-1:0] b_data_i,
    input  logic          c_valid_i,
    output logic          c_ready_o,
    input  logic [DW-1:0] c_data_i,
    output logic          d_valid_o,
    input  logic          d_ready_i,
    output logic [DW-1:0] d_data_o,
    input  ctrl_engine_t  ctrl_i,
    output flags_engine_t flags_o
);

    localparam logic [MAC_CNT_LEN-1:0] CNT_ZERO = {MAC_CNT_LEN{1'b0}};
    localparam logic [MAC_CNT_LEN-1:0] CNT_ONE  = {{(MAC_CNT_LEN-1){1'b0}}, 1'b1};

    logic                   p_valid_s;
    logic [DW-1:0]          p_data_s;

    logic [DW-1:0]          acc_r;
    logic [MAC_CNT_LEN-1:0] cnt_r;
    logic                   d_valid_r;
    logic [DW-1:0]          d_data_r;
    logic                   acc_done_r;

    logic [MAC_CNT_LEN-1:0] len_eff_s;
    logic [MAC_CNT_LEN-1:0] cnt_base_s;
    logic [DW-1:0]          acc_base_s;
    logic [DW-1:0]          acc_term_s;
    logic                   last_s;
    logic                   o_accept_s;
    logic                   p_advance_s;
    logic                   o_load_s;
    logic [DW-1:0]          result_s;

    mac_prod_stage #(
        .DW (DW)
    ) u_prod (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (ctrl_i.clear),
        .enable_i    (ctrl_i.enable),
        .shift_i     (ctrl_i.shift),
        .a_valid_i   (a_valid_i),
        .a_ready_o   (a_ready_o),
        .a_data_i    (a_data_i),
        .b_valid_i   (b_valid_i),
        .b_ready_o   (b_ready_o),
        .b_data_i    (b_data_i),
        .p_valid_o   (p_valid_s),
        .p_data_o    (p_data_s),
        .p_advance_i (p_advance_s)
    );

    // A zero length is treated as a one-element vector
    assign len_eff_s  = (ctrl_i.len == CNT_ZERO) ? CNT_ONE : ctrl_i.len;

    // start rebases the running state in the same cycle, so a coinciding
    // advance is computed as element 1 of a fresh vector
    assign cnt_base_s = ctrl_i.start ? CNT_ZERO : cnt_r;
    assign acc_base_s = ctrl_i.start ? {DW{1'b0}} : acc_r;

    // Element-wise results never include the running sum
    assign acc_term_s = ctrl_i.simple_mul ? {DW{1'b0}} : acc_base_s;

    assign last_s      = ctrl_i.simple_mul | ((cnt_base_s + CNT_ONE) == len_eff_s);
    assign o_accept_s  = ~d_valid_r | d_ready_i;

    // The last element of a vector needs C and room in O; other elements
    // only fold into the accumulator
    assign p_advance_s = p_valid_s & ctrl_i.enable & (~last_s | (c_valid_i & o_accept_s));
    assign o_load_s    = p_advance_s & last_s;
    assign c_ready_o   = o_load_s;

    assign result_s    = acc_term_s + p_data_s + c_data_i;

    // Running sum and element count
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            acc_r <= {DW{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (o_load_s) begin
            acc_r <= {DW{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (p_advance_s) begin
            acc_r <= acc_base_s + p_data_s;
            cnt_r <= cnt_base_s + CNT_ONE;
        end else if (ctrl_i.start) begin
            acc_r <= {DW{1'b0}};
            cnt_r <= CNT_ZERO;
        end
    end

    // Output register and result-done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            d_valid_r  <= 1'b0;
            d_data_r   <= {DW{1'b0}};
            acc_done_r <= 1'b0;
        end else begin
            acc_done_r <= o_load_s;
            if (o_load_s) begin
                d_valid_r <= 1'b1;
                d_data_r  <= result_s;
            end else if (d_ready_i) begin
                d_valid_r <= 1'b0;
            end
        end
    end

    assign d_valid_o        = d_valid_r;
    assign d_data_o         = d_data_r;
    assign flags_o.cnt      = cnt_r;
    assign flags_o.acc_done = acc_done_r;

endmodule
